// File: rtl/uart_rcv_if.sv
// Host-side bundle of the UART receiver: serial line in, received byte plus
// ready/acknowledge handshake and error pulses out.
interface uart_rcv_if;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  modport master (
    input  RX,
    input  clr_rdy,
    output rx_data,
    output rdy,
    output frm_err,
    output ovr_err
  );

  modport slave (
    output RX,
    output clr_rdy,
    input  rx_data,
    input  rdy,
    input  frm_err,
    input  ovr_err
  );
endinterface

// File: rtl/uart_rcv.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling FSM,
// ready flag with consumer acknowledge, framing and overrun error pulses.
module uart_rcv #(
  parameter int BAUD_CYCLES = 44
) (
  input logic        clk,
  input logic        rst_n,
  uart_rcv_if.master bus
);

  localparam logic [5:0] HALF_LOAD = 6'(BAUD_CYCLES / 2 - 1);
  localparam logic [5:0] FULL_LOAD = 6'(BAUD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     state;
  logic       rx_meta;
  logic       rx_s;
  logic [5:0] baud_cnt;
  logic [3:0] bit_cnt;
  logic [8:0] shreg;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.RX;
      rx_s    <= rx_meta;
    end
  end

  // The start bit is shifted in as well and ends up in shreg[0], so a good
  // frame is one that is framed by a low start and a high stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
      frm_err  <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
      if (bus.clr_rdy) begin
        rdy <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            baud_cnt <= HALF_LOAD;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt != 6'd0) begin
            baud_cnt <= baud_cnt - 6'd1;
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            baud_cnt <= FULL_LOAD;
            bit_cnt  <= '0;
            shreg    <= {rx_s, shreg[8:1]};
            state    <= DATA;
          end
        end
        DATA: begin
          if (baud_cnt != 6'd0) begin
            baud_cnt <= baud_cnt - 6'd1;
          end else begin
            shreg    <= {rx_s, shreg[8:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            baud_cnt <= FULL_LOAD;
            if (bit_cnt == 4'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (baud_cnt != 6'd0) begin
            baud_cnt <= baud_cnt - 6'd1;
          end else begin
            // Leaving at mid-stop lets a start bit directly after the stop bit be caught.
            state <= IDLE;
            if (rx_s && !shreg[0]) begin
              rx_data <= shreg[8:1];
              rdy     <= 1'b1;
              ovr_err <= rdy & ~bus.clr_rdy;
            end else begin
              frm_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data = rx_data;
  assign bus.rdy     = rdy;
  assign bus.frm_err = frm_err;
  assign bus.ovr_err = ovr_err;

endmodule

// File: doc/uart_rcv.md
# uart_rcv

UART receiver paired with the design's 8N1 UART transmitter. It synchronizes the asynchronous serial line `RX` and finds the start bit. Each bit is sampled at mid-bit using the same baud timing as the transmitter: 44 clocks per bit by default. The block presents the received byte with a ready flag, and flags framing and overrun errors. It sits between the serial pin and the command/host-interface logic.

## Interface
- `BAUD_CYCLES`, default 44: clocks per bit period. Must be even and ≥ 8.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RX`  in  1  serial input. Asynchronous to `clk`, idles high.
- `clr_rdy`  in  1  consumer acknowledge; clears `rdy`.
- `rx_data`  out  8  last good byte received, LSB first on the line. Reset value 8'h00.
- `rdy`  out  1  high when `rx_data` holds an unconsumed byte. Reset value 0.
- `frm_err`  out  1  one-cycle pulse when the stop bit is sampled as 0. Reset value 0.
- `ovr_err`  out  1  one-cycle pulse when a good byte completes while `rdy` is already 1. Reset value 0.

## Operation
- **Synchronizer.** Two flops on `RX`, both reset to 1. All internal logic uses only the second flop, `rx_s`.
- **Counters.**
  - `baud_cnt` is a 6-bit counter. It is loaded with a start value and counts down; a sample strobe fires when it reaches 0.
  - `bit_cnt` is a 4-bit counter of bits sampled in the current frame.
  - A 9-bit shift register shifts right, with the new bit entering at MSB.
- **FSM states.** IDLE, START, DATA, STOP.
  - **IDLE:** when `rx_s` == 0, go to START and load `baud_cnt` = BAUD_CYCLES/2 − 1.
  - **START:** on the strobe, sample `rx_s`.
    - If 1 (glitch, false start): return to IDLE with no outputs affected.
    - If 0: load `baud_cnt` = BAUD_CYCLES − 1, clear `bit_cnt`, go to DATA.
  - **DATA:** on each strobe, shift `rx_s` in, increment `bit_cnt`, and reload `baud_cnt` = BAUD_CYCLES − 1. After the 8th data bit, go to STOP.
  - **STOP:** on the strobe, sample `rx_s`, then go to IDLE in the next cycle.
    - If 1: load `rx_data` from the shift register and set `rdy`. If `rdy` was already 1, also pulse `ovr_err`; the new data overwrites the old.
    - If 0: pulse `frm_err`. `rx_data` and `rdy` are unchanged.
- **Back-to-back frames.** Returning to IDLE at mid-stop-bit lets the block accept a start bit that immediately follows the stop bit.
- **`rdy` handling.**
  - `rdy` is cleared only by `clr_rdy`.
  - If a set and `clr_rdy` occur in the same cycle, the set wins and `rdy` stays 1, with no `ovr_err`.
  - `clr_rdy` while `rdy` = 0 is a no-op.
- **Reset mid-frame.** Asserting `rst_n` mid-frame returns the block to IDLE immediately and sets all outputs and the synchronizer to their reset values. A partial frame never produces `rdy`.
- **Width rule.** `baud_cnt` is 6 bits, so BAUD_CYCLES ≤ 64.

## Timing
- **Edge E0.** E0 is the first clock edge at which the first synchronizer flop captures `RX` = 0. `rx_s` is 0 after E0+1, and IDLE→START occurs at edge E0+2.
- **Sample points, relative to E0 (defaults):**
  - Start bit sampled at E0+2+BAUD_CYCLES/2 = E0+24.
  - Data bit k (k = 0..7) sampled at E0+24+44·(k+1).
  - Stop bit sampled at E0+24+44·9 = E0+420.
- **Output timing.** `rdy`, `rx_data`, `frm_err` and `ovr_err` update on the stop-sample edge, so they are visible in the cycle after E0+420.
- **Pulse width.** `frm_err` and `ovr_err` are each high for exactly one cycle.
- **Data stability.** `rx_data` is stable from the moment `rdy` rises until the next good stop bit.
- **Tolerance.** Mid-bit sampling tolerates roughly ±40% of a bit period of accumulated drift across the frame.

## Test plan
- **Byte 0xA5.** Reset, then drive 0xA5 from the UART transmitter (44 cycles/bit). Required: `rdy` rises 420±1 cycles after `RX` falls, `rx_data` = 0xA5, `frm_err` = 0, `ovr_err` = 0. Then pulse `clr_rdy`: `rdy` = 0 the next cycle.
- **Back-to-back.** Send 0x00, 0xFF, 0x3C back-to-back with no idle gap and `clr_rdy` pulsed after each `rdy`. Required: three `rdy` assertions carrying 0x00, 0xFF and 0x3C, and no error pulses.
- **Glitch.** Drive a 10-cycle low pulse on an idle `RX`. Required: return to IDLE at the start sample, `rdy` stays 0, no error pulses, and a following 0x55 frame is received correctly.
- **Framing error.** Send 0x81 with the stop bit forced to 0. Required: a single-cycle `frm_err` pulse, `rdy` stays 0, `rx_data` keeps its previous value.
- **Overrun.** Receive 0x12 without asserting `clr_rdy`, then receive 0x34. Required: `ovr_err` pulses once, `rx_data` = 0x34, `rdy` = 1. Also check that `clr_rdy` asserted on the same edge as the stop sample leaves `rdy` = 1.
- **Reset mid-frame.** Assert `rst_n` low during data bit 4 of a frame. Required: all outputs at their reset values, no `rdy`, and the next full frame 0xC3 is received correctly.
